route_lookup: RTL and testbench
===============================

ROUTE_LOOKUP -- requirements
Module: route_lookup

Interface
REQ-001 SHALL provide parameter CHANNELS, default 5, number of router input channels requesting lookups.
REQ-002 SHALL provide parameter CHANNEL_BITS, default 8, width of an output-port number.
REQ-003 SHALL provide parameter DEST_BITS, default 7, width of a destination address; table depth 2**DEST_BITS.
REQ-004 SHALL provide parameter DEFAULT_PORT, default 4, port returned on a miss.
REQ-005 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL provide port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL provide port cfg_we, input, 1, table write strobe.
REQ-008 SHALL provide port cfg_addr, input, DEST_BITS, write address.
REQ-009 SHALL provide port cfg_data, input, CHANNEL_BITS, output port to store.
REQ-010 SHALL provide port cfg_valid, input, 1, entry valid bit to store (0 invalidates).
REQ-011 SHALL provide port req_valid, input, CHANNELS, per-channel lookup request.
REQ-012 SHALL provide port req_dest, input, CHANNELS*DEST_BITS, packed destinations, channel i at bits [i*DEST_BITS +: DEST_BITS].
REQ-013 SHALL provide port req_ready, output, CHANNELS, one-hot-or-zero grant.
REQ-014 SHALL provide port rsp_valid, output, CHANNELS, one-cycle response strobe.
REQ-015 SHALL provide port rsp_port, output, CHANNELS*CHANNEL_BITS, packed result ports, same packing as req_dest.
REQ-016 SHALL provide port rsp_miss, output, CHANNELS, response was a miss.
REQ-017 SHALL provide port miss_count, output, 16, saturating miss counter.

Function
REQ-018 SHALL hold table of 2**DEST_BITS entries, each {valid, port[CHANNEL_BITS-1:0]}.
REQ-019 SHALL write entry cfg_addr with {cfg_valid, cfg_data} at the clock edge where cfg_we=1.
REQ-020 SHALL accept at most one lookup per cycle; handshake completes when req_valid[i] & req_ready[i].
REQ-021 SHALL drive req_ready combinationally: highest-priority requesting channel per round-robin pointer; all zero if no req_valid.
REQ-022 SHALL advance round-robin pointer to (granted+1) mod CHANNELS after each grant; pointer unchanged in idle cycles.
REQ-023 SHALL assert rsp_valid[i] exactly one cycle after channel i's handshake, for one cycle; latency fixed at 1.
REQ-024 SHALL return stored port and rsp_miss=0 for a valid entry; DEFAULT_PORT and rsp_miss=1 for invalid entry.
REQ-025 SHALL hold rsp_port/rsp_miss of a channel stable until its next response; other channels' fields unaffected.
REQ-026 SHALL, when cfg_we writes the address looked up in the same cycle, return the newly written value (write bypass).
REQ-027 SHALL increment miss_count by 1 per miss response, saturating at 16'hFFFF.
REQ-028 SHALL tolerate a requester dropping req_valid before grant; no response generated for it.

Reset
REQ-029 SHALL, on reset, clear all entry valid bits, pointer to 0, rsp_valid to 0, rsp_port fields to DEFAULT_PORT, rsp_miss to 0, miss_count to 0.
REQ-030 SHALL discard any lookup in flight when reset asserts mid-operation; no rsp_valid in cycle after reset release.
REQ-031 SHALL keep req_ready all zero while reset is high.

Structure
REQ-032 SHALL place default parameter values and entry field widths in shared package route_pkg.
REQ-033 SHALL implement arbitration in sub-module rr_arbiter (parameter N; inputs clk, reset, req[N], advance; output grant[N] one-hot).
REQ-034 SHALL implement table as flip-flop array with synchronous write, combinational read; no vendor memory macro.

Verification
REQ-035 Reset, then lookup dest 3 on channel 0 -> rsp_valid[0] one cycle later, rsp_port=4, rsp_miss=1, miss_count=1.
REQ-036 Write addr 1 port 2 valid, then lookup dest 1 on channel 2 -> rsp_port[2]=2, rsp_miss=0, miss_count unchanged.
REQ-037 All 5 channels request continuously from pointer 0 -> grants in order 0,1,2,3,4,0, one per cycle, each rsp one cycle later.
REQ-038 Same cycle: cfg_we addr 5 port 1 valid and channel 3 lookups dest 5 -> rsp_port[3]=1, rsp_miss=0.
REQ-039 Preload miss_count to 16'hFFFE via 2 less than saturation of misses (or forced), issue 3 misses -> miss_count stays 16'hFFFF.
REQ-040 Assert reset asynchronously one cycle after a grant -> rsp_valid stays 0, valid bits cleared, subsequent lookup of previously written entry misses.

Source files
------------

// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : route_pkg
//  Description : Shared defaults, entry field widths and helpers for the
//                route lookup block.
//  Revision    : 1.0 - initial release
// ============================================================================
package route_pkg;

    localparam int c_CHANNELS     = 5;
    localparam int c_CHANNEL_BITS = 8;
    localparam int c_DEST_BITS    = 7;
    localparam int c_DEFAULT_PORT = 4;
    localparam int c_MISS_W       = 16;
    localparam int c_VALID_W      = 1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [c_MISS_W-1:0] sat_inc(input logic [c_MISS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/route_lookup_if.sv
`default_nettype none
// ============================================================================
//  Module      : route_lookup_if
//  Description : Configuration, request and response bundle of the route
//                lookup block. master = requesting side, slave = lookup block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface route_lookup_if
    import route_pkg::*;
#(
    parameter int CHANNELS     = c_CHANNELS,
    parameter int CHANNEL_BITS = c_CHANNEL_BITS,
    parameter int DEST_BITS    = c_DEST_BITS
);
    logic                             cfg_we;
    logic [DEST_BITS-1:0]             cfg_addr;
    logic [CHANNEL_BITS-1:0]          cfg_data;
    logic                             cfg_valid;
    logic [CHANNELS-1:0]              req_valid;
    logic [CHANNELS*DEST_BITS-1:0]    req_dest;
    logic [CHANNELS-1:0]              req_ready;
    logic [CHANNELS-1:0]              rsp_valid;
    logic [CHANNELS*CHANNEL_BITS-1:0] rsp_port;
    logic [CHANNELS-1:0]              rsp_miss;
    logic [c_MISS_W-1:0]              miss_count;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_valid, req_valid, req_dest,
        input  req_ready, rsp_valid, rsp_port, rsp_miss, miss_count
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_valid, req_valid, req_dest,
        output req_ready, rsp_valid, rsp_port, rsp_miss, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/route_lookup_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Grant is combinational from the
//                request vector; the pointer moves past the winner on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic [N-1:0] req,
    input  wire logic         advance,
    output logic      [N-1:0] grant
);
    localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_idx;
    logic [c_PTR_W-1:0] w_cand;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic               w_found;

    // Search from the pointer upward (wrapping) for the first requester
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = c_PTR_W'((int'(r_ptr) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        w_next_ptr = (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        // Nothing may be granted while reset is held
        grant = (w_found && !reset) ? (N'(1) << w_idx) : '0;
    end

    // Pointer moves just past the winner; idle cycles leave it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end
endmodule
`default_nettype wire

// File: rtl/route_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : route_lookup
//  Description : Destination -> output-port lookup table shared by several
//                router input channels. One lookup per cycle, round-robin
//                arbitrated, one-cycle response latency, write bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module route_lookup
    import route_pkg::*;
#(
    parameter int CHANNELS     = c_CHANNELS,
    parameter int CHANNEL_BITS = c_CHANNEL_BITS,
    parameter int DEST_BITS    = c_DEST_BITS,
    parameter int DEFAULT_PORT = c_DEFAULT_PORT
) (
    input  wire logic      clk,
    input  wire logic      reset,
    route_lookup_if.slave  bus
);
    localparam int c_DEPTH = 2 ** DEST_BITS;
    localparam logic [CHANNEL_BITS-1:0] c_DEF_PORT = CHANNEL_BITS'(DEFAULT_PORT);

    logic [c_DEPTH-1:0]               r_tbl_valid;
    logic [CHANNEL_BITS-1:0]          r_tbl_port [c_DEPTH];
    logic [CHANNELS-1:0]              r_rsp_valid;
    logic [CHANNELS*CHANNEL_BITS-1:0] r_rsp_port;
    logic [CHANNELS-1:0]              r_rsp_miss;
    logic [c_MISS_W-1:0]              r_miss_count;

    logic [CHANNELS-1:0]              w_grant;
    logic                             w_take;
    logic [DEST_BITS-1:0]             w_dest;
    logic                             w_hit;
    logic [CHANNEL_BITS-1:0]          w_port;

    rr_arbiter #(
        .N (CHANNELS)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (w_take),
        .grant   (w_grant)
    );

    // The grant is only ever given to a requester, so any grant is a handshake
    assign w_take        = |w_grant;
    assign bus.req_ready = w_grant;

    // Pick the granted channel's destination and read the table, letting a
    // same-cycle write to that address take precedence
    always_comb begin
        w_dest = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_dest = bus.req_dest[i*DEST_BITS +: DEST_BITS];
            end
        end
        if (bus.cfg_we && (bus.cfg_addr == w_dest)) begin
            w_hit = bus.cfg_valid;
            w_port = bus.cfg_data;
        end else begin
            w_hit = r_tbl_valid[w_dest];
            w_port = r_tbl_port[w_dest];
        end
        if (!w_hit) begin
            w_port = c_DEF_PORT;
        end
    end

    // Entry valid bits: cleared by reset, written by the config port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tbl_valid <= '0;
        end else if (bus.cfg_we) begin
            r_tbl_valid[bus.cfg_addr] <= bus.cfg_valid;
        end
    end

    // Entry port fields need no reset; they are masked by the valid bit
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            r_tbl_port[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Response registers: strobe for one cycle, fields held until next use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_rsp_miss   <= '0;
            r_miss_count <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_rsp_port[i*CHANNEL_BITS +: CHANNEL_BITS] <= c_DEF_PORT;
            end
        end else begin
            r_rsp_valid <= w_grant;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_grant[i]) begin
                    r_rsp_port[i*CHANNEL_BITS +: CHANNEL_BITS] <= w_port;
                    r_rsp_miss[i] <= ~w_hit;
                end
            end
            if (w_take && !w_hit) begin
                r_miss_count <= sat_inc(r_miss_count);
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_port   = r_rsp_port;
    assign bus.rsp_miss   = r_rsp_miss;
    assign bus.miss_count = r_miss_count;
endmodule
`default_nettype wire

// File: tb/tb_route_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : tb_route_lookup
//  Description : Randomized scoreboard bench for route_lookup with a
//                behavioural table / round-robin / counter reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_route_lookup;
    localparam int c_CH = 5;
    localparam int c_CB = 8;
    localparam int c_DB = 7;
    localparam int c_DEF = 4;

    typedef struct {
        int ch;
        int port;
        bit miss;
        int cnt;
    } exp_t;

    logic clk;
    logic reset;

    route_lookup_if #(.CHANNELS(c_CH), .CHANNEL_BITS(c_CB), .DEST_BITS(c_DB)) bus ();

    route_lookup #(
        .CHANNELS     (c_CH),
        .CHANNEL_BITS (c_CB),
        .DEST_BITS    (c_DB),
        .DEFAULT_PORT (c_DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    bit   m_tbl_v [128];
    int   m_tbl_p [128];
    int   m_ptr;
    int   m_cnt;
    int   m_port [c_CH];
    bit   m_miss [c_CH];
    exp_t exp_q [$];

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [c_CH*c_DB-1:0] one_dest(input int ch, input int d);
        logic [c_CH*c_DB-1:0] v;
        v = '0;
        v[ch*c_DB +: c_DB] = c_DB'(d);
        return v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 128; a++) m_tbl_v[a] = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        for (int c = 0; c < c_CH; c++) begin
            m_port[c] = c_DEF;
            m_miss[c] = 1'b0;
        end
        exp_q.delete();
    endtask

    // One cycle of stimulus; the model predicts grant and queues the response
    task automatic do_cycle(input logic [c_CH-1:0] rv, input logic [c_CH*c_DB-1:0] dests,
                            input bit we, input int addr, input int data, input bit v,
                            output logic [c_CH-1:0] rdy);
        int g;
        int d;
        bit hv;
        int hp;
        exp_t e;
        @(negedge clk);
        bus.req_valid = rv;
        bus.req_dest  = dests;
        bus.cfg_we    = we;
        bus.cfg_addr  = c_DB'(addr);
        bus.cfg_data  = c_CB'(data);
        bus.cfg_valid = v;
        #1;
        rdy = bus.req_ready;
        g = -1;
        for (int k = 0; k < c_CH; k++) begin
            if (g < 0 && rv[(m_ptr + k) % c_CH]) g = (m_ptr + k) % c_CH;
        end
        chk("req_ready", 64'(rdy), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            d = int'(dests[g*c_DB +: c_DB]);
            if (we && addr == d) begin
                hv = v;
                hp = data;
            end else begin
                hv = m_tbl_v[d];
                hp = m_tbl_p[d];
            end
            e.ch   = g;
            e.miss = !hv;
            e.port = hv ? hp : c_DEF;
            if (!hv && m_cnt < 65535) m_cnt++;
            e.cnt  = m_cnt;
            exp_q.push_back(e);
            m_ptr = (g + 1) % c_CH;
        end
        if (we) begin
            m_tbl_v[addr] = v;
            m_tbl_p[addr] = data;
        end
    endtask

    // Monitor: every cycle, the response strobe and all held fields must match
    always @(posedge clk) begin
        exp_t e;
        logic [c_CH*c_CB-1:0] ep;
        logic [c_CH-1:0]      em;
        #1;
        if (reset) begin
            chk("rsp_valid_in_reset", 64'(bus.rsp_valid), 64'd0);
            chk("req_ready_in_reset", 64'(bus.req_ready), 64'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_valid", 64'(bus.rsp_valid), 64'd1 << e.ch);
            chk("miss_count", 64'(bus.miss_count), 64'(e.cnt));
            m_port[e.ch] = e.port;
            m_miss[e.ch] = e.miss;
        end else begin
            chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
        end
        for (int c = 0; c < c_CH; c++) begin
            ep[c*c_CB +: c_CB] = c_CB'(m_port[c]);
            em[c] = m_miss[c];
        end
        chk("rsp_port", 64'(bus.rsp_port), 64'(ep));
        chk("rsp_miss", 64'(bus.rsp_miss), 64'(em));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_CH-1:0]      rdy;
        logic [c_CH*c_DB-1:0] dv;
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        reset         = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.cfg_valid = 1'b0;
        bus.req_valid = '0;
        bus.req_dest  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_miss_count", 64'(bus.miss_count), 64'd0);

        // Lookup of an empty table misses on channel 0
        do_cycle(5'b00001, one_dest(0, 3), 0, 0, 0, 0, rdy);
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("miss_port_ch0", 64'(bus.rsp_port[7:0]), 64'd4);
        chk("miss_flag_ch0", 64'(bus.rsp_miss[0]), 64'd1);
        chk("miss_count_1", 64'(bus.miss_count), 64'd1);

        // Written entry hits on channel 2 without touching the counter
        do_cycle('0, '0, 1, 1, 2, 1, rdy);
        do_cycle(5'b00100, one_dest(2, 1), 0, 0, 0, 0, rdy);
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("hit_port_ch2", 64'(bus.rsp_port[23:16]), 64'd2);
        chk("hit_flag_ch2", 64'(bus.rsp_miss[2]), 64'd0);
        chk("hit_count", 64'(bus.miss_count), 64'd1);

        // Bring the pointer back to 0, then all channels request continuously
        do_cycle(5'b10000, one_dest(4, 1), 0, 0, 0, 0, rdy);
        for (int i = 0; i < 6; i++) begin
            dv = '0;
            for (int c = 0; c < c_CH; c++) dv[c*c_DB +: c_DB] = c_DB'($urandom_range(0, 3));
            do_cycle(5'b11111, dv, 0, 0, 0, 0, rdy);
            chk("rr_order", 64'(rdy), 64'd1 << (i % c_CH));
        end
        do_cycle('0, '0, 0, 0, 0, 0, rdy);

        // Same-cycle write and lookup of address 5 on channel 3
        do_cycle(5'b01000, one_dest(3, 5), 1, 5, 1, 1, rdy);
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("bypass_port_ch3", 64'(bus.rsp_port[31:24]), 64'd1);
        chk("bypass_flag_ch3", 64'(bus.rsp_miss[3]), 64'd0);

        // Random traffic: requests appear and vanish, config writes interleave
        for (int i = 0; i < 400; i++) begin
            dv = '0;
            for (int c = 0; c < c_CH; c++) dv[c*c_DB +: c_DB] = c_DB'($urandom_range(0, 15));
            do_cycle(c_CH'($urandom), dv, ($urandom_range(0, 2) == 0),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                     bit'($urandom_range(0, 1)), rdy);
        end

        // Run the miss counter up to one below saturation (address 100 never written)
        while (m_cnt < 16'hFFFE) begin
            do_cycle(5'b00001, one_dest(0, 100), 0, 0, 0, 0, rdy);
        end
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("count_preload", 64'(bus.miss_count), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            do_cycle(5'b00010, one_dest(1, 100), 0, 0, 0, 0, rdy);
        end
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("count_saturated", 64'(bus.miss_count), 64'hFFFF);

        // Reset hitting a lookup in flight
        do_cycle('0, '0, 1, 9, 7, 1, rdy);
        do_cycle(5'b00010, one_dest(1, 9), 0, 0, 0, 0, rdy);
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("pre_reset_hit", 64'(bus.rsp_port[15:8]), 64'd7);
        @(negedge clk);
        bus.req_valid = 5'b00100;
        bus.req_dest  = one_dest(2, 9);
        #1;
        chk("grant_before_reset", 64'(bus.req_ready), 64'(5'b00100));
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("ready_during_reset", 64'(bus.req_ready), 64'd0);
        chk("count_cleared", 64'(bus.miss_count), 64'd0);
        repeat (2) @(negedge clk);
        bus.req_valid = '0;
        reset = 1'b0;
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        do_cycle(5'b00001, one_dest(0, 9), 0, 0, 0, 0, rdy);
        do_cycle('0, '0, 0, 0, 0, 0, rdy);
        chk("post_reset_miss", 64'(bus.rsp_miss[0]), 64'd1);
        chk("post_reset_port", 64'(bus.rsp_port[7:0]), 64'd4);
        chk("post_reset_count", 64'(bus.miss_count), 64'd1);
        do_cycle('0, '0, 0, 0, 0, 0, rdy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
